// File: rtl/soc_pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : soc_pwm_pkg
// Description : Shared definitions for the PWM controller: Avalon register
//               word addresses, CTRL/STATUS bit positions and the common
//               reset value for every register, shadow and counter.
// Revision    : 1.0 - initial release
// ============================================================================
package soc_pwm_pkg;

    // Register word addresses
    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_PRESC  = 3'd1;
    localparam logic [2:0] ADDR_PERIOD = 3'd2;
    localparam logic [2:0] ADDR_DUTY   = 3'd3;
    localparam logic [2:0] ADDR_STATUS = 3'd4;
    localparam logic [2:0] ADDR_COUNT  = 3'd5;

    // CTRL bit positions
    localparam int CTRL_EN     = 0;
    localparam int CTRL_INV    = 1;
    localparam int CTRL_IRQ_EN = 2;

    // STATUS bit positions
    localparam int STATUS_PEF  = 0;

    // Reset value of every register, shadow and counter
    localparam logic [31:0] RESET_VAL = 32'd0;

endpackage : soc_pwm_pkg
`default_nettype wire

// File: rtl/soc_pwm_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : soc_pwm_tick_gen
// Description : Prescaler for the PWM period counter. Holds a shadow copy of
//               PRESC and a counter that runs 0..PRESC_sh; o_tick is high in
//               the cycle the counter sits at PRESC_sh, so ticks are
//               PRESC_sh+1 clocks apart.
// Ports       : clk      - system clock
//               reset_n  - asynchronous active-low reset
//               i_presc  - live PRESC register value
//               i_load   - copy i_presc into the shadow this clock
//               i_clear  - hold the counter at 0 and suppress ticks
//               o_tick   - prescaler tick (combinational from state)
// Revision    : 1.0 - initial release
// ============================================================================
module soc_pwm_tick_gen
    import soc_pwm_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [CNT_W-1:0] i_presc,
    input  logic             i_load,
    input  logic             i_clear,
    output logic             o_tick
);

    logic [CNT_W-1:0] r_presc_sh;
    logic [CNT_W-1:0] r_pcnt;

    assign o_tick = !i_clear && (r_pcnt == r_presc_sh);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc_sh <= RESET_VAL[CNT_W-1:0];
            r_pcnt     <= RESET_VAL[CNT_W-1:0];
        end else begin
            if (i_load) begin
                r_presc_sh <= i_presc;
            end
            // A load always coincides with either a clear (enable edge) or a
            // tick (period wrap), so the counter restarts from 0 with the
            // freshly loaded shadow.
            if (i_clear || o_tick) begin
                r_pcnt <= '0;
            end else begin
                r_pcnt <= r_pcnt + 1'b1;
            end
        end
    end

endmodule : soc_pwm_tick_gen
`default_nettype wire

// File: rtl/soc_pwm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : soc_pwm_ctrl
// Description : Avalon-MM slave PWM controller. Live PRESC/PERIOD/DUTY
//               registers are copied into shadows when EN rises and at every
//               period wrap, so software updates never glitch the output.
//               Register map: 0 CTRL, 1 PRESC, 2 PERIOD, 3 DUTY,
//               4 STATUS (PEF, W1C), 5 COUNT (RO); 6-7 read 0.
// Ports       : clk, reset_n         - clock, asynchronous active-low reset
//               address, chipselect,
//               write_n, writedata   - Avalon-MM write side
//               readdata             - zero-wait-state combinational read
//               pwm_out              - registered PWM output
//               irq                  - PEF && IRQ_EN (PWM_IRQ_EN builds only)
// Config      : `define PWM_IRQ_EN adds the irq port and CTRL.IRQ_EN; without
//               it CTRL bit2 reads 0 and PEF is poll-only.
// Revision    : 1.0 - initial release
// ============================================================================
module soc_pwm_ctrl
    import soc_pwm_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        pwm_out
`ifdef PWM_IRQ_EN
    ,
    output logic        irq
`endif
);

    // Live software-visible registers
    logic             r_en;
    logic             r_inv;
    logic [CNT_W-1:0] r_presc;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_duty;

    // Shadows in use by the running waveform
    logic [CNT_W-1:0] r_period_sh;
    logic [CNT_W-1:0] r_duty_sh;

    logic [CNT_W-1:0] r_cnt;
    logic             r_pef;
    logic             r_pwm;
    logic             w_irq_en;

    logic             w_wr;
    logic             w_en_rise;
    logic             w_tick;
    logic             w_wrap;
    logic             w_load;
    logic             w_pef_clr;

    assign w_wr      = chipselect && !write_n;
    assign w_en_rise = w_wr && (address == ADDR_CTRL) && writedata[CTRL_EN] && !r_en;
    assign w_wrap    = w_tick && (r_cnt == r_period_sh);
    assign w_load    = w_en_rise || w_wrap;
    assign w_pef_clr = w_wr && (address == ADDR_STATUS) && writedata[STATUS_PEF];

    soc_pwm_tick_gen #(
        .CNT_W (CNT_W)
    ) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .i_presc (r_presc),
        .i_load  (w_load),
        .i_clear (!r_en),
        .o_tick  (w_tick)
    );

`ifdef PWM_IRQ_EN
    logic r_irq_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_en <= RESET_VAL[CTRL_IRQ_EN];
        end else if (w_wr && (address == ADDR_CTRL)) begin
            r_irq_en <= writedata[CTRL_IRQ_EN];
        end
    end

    assign w_irq_en = r_irq_en;
    assign irq      = r_pef && r_irq_en;
`else
    assign w_irq_en = 1'b0;
`endif

    // Register file
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_en     <= RESET_VAL[CTRL_EN];
            r_inv    <= RESET_VAL[CTRL_INV];
            r_presc  <= RESET_VAL[CNT_W-1:0];
            r_period <= RESET_VAL[CNT_W-1:0];
            r_duty   <= RESET_VAL[CNT_W-1:0];
        end else if (w_wr) begin
            case (address)
                ADDR_CTRL: begin
                    r_en  <= writedata[CTRL_EN];
                    r_inv <= writedata[CTRL_INV];
                end
                ADDR_PRESC:  r_presc  <= writedata[CNT_W-1:0];
                ADDR_PERIOD: r_period <= writedata[CNT_W-1:0];
                ADDR_DUTY:   r_duty   <= writedata[CNT_W-1:0];
                default: ;
            endcase
        end
    end

    // Shadows, period counter, status flag and output register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_period_sh <= RESET_VAL[CNT_W-1:0];
            r_duty_sh   <= RESET_VAL[CNT_W-1:0];
            r_cnt       <= RESET_VAL[CNT_W-1:0];
            r_pef       <= RESET_VAL[STATUS_PEF];
            r_pwm       <= 1'b0;
        end else begin
            if (w_load) begin
                r_period_sh <= r_period;
                r_duty_sh   <= r_duty;
            end

            if (!r_en || w_wrap) begin
                r_cnt <= '0;
            end else if (w_tick) begin
                r_cnt <= r_cnt + 1'b1;
            end

            // A wrap in the same cycle as a W1C keeps the flag set.
            if (w_wrap) begin
                r_pef <= 1'b1;
            end else if (w_pef_clr) begin
                r_pef <= 1'b0;
            end

            // Disabled: drive the inactive level straight away.
            if (r_en) begin
                r_pwm <= (r_cnt < r_duty_sh) ^ r_inv;
            end else begin
                r_pwm <= r_inv;
            end
        end
    end

    assign pwm_out = r_pwm;

    // Read mux
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL: begin
                readdata[CTRL_EN]     = r_en;
                readdata[CTRL_INV]    = r_inv;
                readdata[CTRL_IRQ_EN] = w_irq_en;
            end
            ADDR_PRESC:  readdata = 32'(r_presc);
            ADDR_PERIOD: readdata = 32'(r_period);
            ADDR_DUTY:   readdata = 32'(r_duty);
            ADDR_STATUS: readdata[STATUS_PEF] = r_pef;
            ADDR_COUNT:  readdata = 32'(r_cnt);
            default:     readdata = '0;
        endcase
    end

endmodule : soc_pwm_ctrl
`default_nettype wire

// File: doc/soc_pwm_ctrl.md
# soc_pwm_ctrl

Avalon-MM slave PWM controller for the SoC's fan/heater drive path: it owns the prescaler, period and duty registers that the Nios software writes, and sequences one PWM output from them. Shadow registers make updates glitch-free by committing only at a period boundary. The block sits beside the GPIO PIOs on the same Avalon interconnect and gives the temperature control loop a single, self-consistent PWM resource.

## Interface
- CNT_W, 32, width of the prescaler, period, duty and counter registers (2..32)
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  3  register word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe; a write occurs when chipselect && !write_n
- writedata  in  32  write data
- readdata  out  32  combinational read mux, zero wait states; unused bits read 0
- pwm_out  out  1  registered PWM output
- irq  out  1  level interrupt, only present when PWM_IRQ_EN is defined

## Operation
- Register map: 0 CTRL (bit0 EN, bit1 INV, bit2 IRQ_EN), 1 PRESC, 2 PERIOD, 3 DUTY, 4 STATUS (bit0 PEF, write-1-to-clear), 5 COUNT (read-only: current period counter). Addresses 6–7: writes ignored, reads return 0.
- Writes to PRESC/PERIOD/DUTY update the live registers. The prescaler, period and duty actually in use are held in shadow registers.
- Shadow load happens in two cases: on the cycle EN goes 0→1, and on every period wrap while EN=1.
- Prescaler: pcnt counts 0..PRESC_sh. A tick occurs when pcnt==PRESC_sh, and pcnt then returns to 0. The tick period is PRESC_sh+1 clocks, so PRESC=0 gives a tick every clock.
- Period counter: on each tick, cnt counts 0..PERIOD_sh and then wraps to 0. The PWM period is (PERIOD_sh+1)×(PRESC_sh+1) clocks.
- Raw output = (cnt < DUTY_sh). pwm_out = raw XOR INV.
  - DUTY=0 gives a constant low.
  - DUTY>PERIOD gives a constant high (100%).
- Wrap event: a tick while cnt==PERIOD_sh. On a wrap, PEF is set, shadows are reloaded and cnt returns to 0.
- Simultaneous wrap and STATUS W1C in the same cycle: set wins, and PEF stays 1.
- EN=0: pcnt and cnt are held at 0 and pwm_out = INV (inactive level). No ticks or wraps occur.
- Clearing EN mid-period forces the output inactive on the next clock. The partial period is abandoned.
- Reset: all registers, shadows and counters are 0. pwm_out=0 and irq=0.
- Arithmetic is unsigned, CNT_W bits. Only writedata[CNT_W-1:0] is used.

## Timing
- Register write takes effect in the register on the clock edge of the write cycle.
- readdata is valid in the same cycle as address.
- pwm_out is registered: it reflects the cnt/duty comparison one clock after the counters change.
- The first tick after EN rises comes PRESC+1 clocks later.
- pwm_out is high for the first DUTY×(PRESC+1) clocks of each period, offset by the 1-clock register latency.
- PEF is set on the clock after the wrap tick. irq follows PEF && IRQ_EN combinationally from registered state.

## Configuration
- PWM_IRQ_EN defined:
  - CTRL bit2 IRQ_EN is implemented.
  - The irq port exists, and irq = PEF && IRQ_EN.
- PWM_IRQ_EN undefined:
  - The irq port is absent.
  - CTRL bit2 reads 0 and ignores writes.
  - PEF remains pollable through STATUS.

## Structure
- Shared package soc_pwm_pkg holds:
  - register address constants (ADDR_CTRL…ADDR_COUNT);
  - CTRL bit index constants;
  - the reset value (0).
- One sub-module, soc_pwm_tick_gen: the prescaler counter with shadow PRESC. It outputs the tick and accepts the load and clear inputs.
- The top level holds the Avalon register file, shadows, period counter, compare logic, STATUS and irq.

## Test plan
- Reset: assert reset_n=0 mid-operation -> pwm_out=0, readdata at every address =0, irq=0.
- Write PRESC=1, PERIOD=3, DUTY=2, then EN=1 -> pwm_out period of 8 clocks, high for 4; PEF=1 after the first wrap; COUNT cycles 0,1,2,3.
- Mid-period write of DUTY=1 -> current period keeps 4-clock high; the next period is high for 2 clocks (no glitch).
- Boundaries: DUTY=0 -> constant 0; DUTY=5 with PERIOD=3 -> constant 1; INV=1 with EN=0 -> pwm_out=1.
- STATUS write 1 in the same cycle as a wrap -> PEF remains 1; a later write of 1 -> PEF=0.
- PWM_IRQ_EN defined, IRQ_EN=1 -> irq rises with PEF and falls on W1C. Undefined -> CTRL reads back bit2=0.
